// File: rtl/phy_pkg.sv
// Shared PHY receive definitions: lane width, the K28.5 comma symbol and
// the alignment state encoding.
package phy_pkg;

    localparam logic [7:0] COMMA_K28_5 = 8'hBC;
    localparam int         LANE_W      = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial-in / byte-out bundle between the bit-clock source and the receive
// deserialiser.
interface serial_to_parallel_rx_if;
    import phy_pkg::*;

    logic              data_in;
    logic [LANE_W-1:0] data_out;
    logic              valid_out;
    logic              byte_strobe;
    logic              active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );

endinterface

// File: rtl/comma_align_fsm.sv
// Comma alignment controller: hunts for a comma at any bit offset, then
// requires N_COMMA consecutive commas on the same byte grid before locking.
module comma_align_fsm
    import phy_pkg::*;
#(
    parameter int N_COMMA = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_is_comma,
    input  logic [2:0] bit_cnt,
    output rx_state_t  state,
    output logic [3:0] comma_cnt,
    output logic       byte_boundary
);

    localparam logic [3:0] N_COMMA_C = 4'(N_COMMA);

    rx_state_t  state_r;
    logic [3:0] comma_cnt_r;

    // Alignment state and consecutive-comma count; ACTIVE is left only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= SEARCH;
            comma_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                SEARCH: begin
                    if (w_is_comma) begin
                        comma_cnt_r <= 4'd1;
                        state_r     <= (N_COMMA_C == 4'd1) ? ACTIVE : ALIGN;
                    end else begin
                        comma_cnt_r <= 4'd0;
                        state_r     <= SEARCH;
                    end
                end
                ALIGN: begin
                    if (bit_cnt == 3'd7) begin
                        if (w_is_comma) begin
                            comma_cnt_r <= comma_cnt_r + 4'd1;
                            state_r     <= ((comma_cnt_r + 4'd1) == N_COMMA_C) ? ACTIVE : ALIGN;
                        end else begin
                            // A broken grid discards this window; the hunt restarts next bit.
                            comma_cnt_r <= 4'd0;
                            state_r     <= SEARCH;
                        end
                    end else begin
                        comma_cnt_r <= comma_cnt_r;
                        state_r     <= ALIGN;
                    end
                end
                ACTIVE: begin
                    comma_cnt_r <= comma_cnt_r;
                    state_r     <= ACTIVE;
                end
                default: begin
                    comma_cnt_r <= 4'd0;
                    state_r     <= SEARCH;
                end
            endcase
        end
    end

    assign state         = state_r;
    assign comma_cnt     = comma_cnt_r;
    assign byte_boundary = (state_r == ACTIVE) && (bit_cnt == 3'd7);

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: comma-aligned byte assembly from the 1-bit
// PHY stream, reporting data bytes with a valid flag and a byte strobe.
module serial_to_parallel_rx
    import phy_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter logic [7:0]  COMMA   = COMMA_K28_5,
    parameter int          N_COMMA = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_to_parallel_rx_if.slave  rx
);

    localparam logic [3:0] N_COMMA_C = 4'(N_COMMA);

    // The current bit completes the window, so only DATA_W-1 history bits are kept.
    logic [DATA_W-2:0] sr_r;
    logic [DATA_W-1:0] w_s;
    logic              w_is_comma_s;
    logic [2:0]        bit_cnt_r;
    rx_state_t         state_s;
    logic [3:0]        comma_cnt_s;
    logic              byte_boundary_s;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              strobe_r;

    assign w_s          = {sr_r, rx.data_in};
    assign w_is_comma_s = (w_s == COMMA);

    // Serial history shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_r <= '0;
        end else begin
            sr_r <= w_s[DATA_W-2:0];
        end
    end

    // Bit position within the aligned byte; pinned to zero while hunting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_r <= 3'd0;
        end else if (state_s == SEARCH) begin
            bit_cnt_r <= 3'd0;
        end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

    comma_align_fsm #(
        .N_COMMA (N_COMMA)
    ) u_fsm (
        .clk           (clk),
        .reset         (reset),
        .w_is_comma    (w_is_comma_s),
        .bit_cnt       (bit_cnt_r),
        .state         (state_s),
        .comma_cnt     (comma_cnt_s),
        .byte_boundary (byte_boundary_s)
    );

    // Byte output registers, updated once per aligned byte in ACTIVE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r   <= '0;
            valid_r  <= 1'b0;
            strobe_r <= 1'b0;
        end else if (byte_boundary_s) begin
            data_r   <= w_s;
            valid_r  <= !w_is_comma_s;
            strobe_r <= 1'b1;
        end else begin
            data_r   <= data_r;
            valid_r  <= valid_r;
            strobe_r <= 1'b0;
        end
    end

    assign rx.data_out    = data_r;
    assign rx.valid_out   = valid_r;
    assign rx.byte_strobe = strobe_r;
    // Lock also implies the comma count has saturated at its target.
    assign rx.active      = (state_s == ACTIVE) && (comma_cnt_s == N_COMMA_C);

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: directed lock/data scenarios
// plus random streams checked against a position-based reference model.
module tb_serial_to_parallel_rx;

    localparam logic [7:0] COMMA_V = 8'hBC;
    localparam int         N_C     = 4;

    logic clk;
    logic reset;
    serial_to_parallel_rx_if rx();

    serial_to_parallel_rx #(
        .DATA_W  (8),
        .COMMA   (COMMA_V),
        .N_COMMA (N_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bit index since reset, anchor position of the candidate
    // comma grid, and the position at which lock was declared.
    logic [7:0] m_hist;
    int         m_n, m_anchor, m_cnt, m_lock_pos;
    bit         m_locked;
    logic [7:0] exp_data;
    logic       exp_valid, exp_strobe, exp_active;

    function automatic void model_step(input logic b, input logic r);
        logic [7:0] win;
        if (!r) begin
            m_hist = 8'h00; m_n = 0; m_anchor = -1; m_cnt = 0; m_lock_pos = 0;
            m_locked = 1'b0;
            exp_data = 8'h00; exp_valid = 1'b0; exp_strobe = 1'b0; exp_active = 1'b0;
            return;
        end
        win    = {m_hist[6:0], b};
        m_hist = win;
        m_n    = m_n + 1;
        if (m_locked) begin
            if (((m_n - m_lock_pos) % 8) == 0) begin
                exp_data = win; exp_valid = (win != COMMA_V); exp_strobe = 1'b1;
            end else begin
                exp_strobe = 1'b0;
            end
        end else begin
            exp_strobe = 1'b0;
            if (m_anchor < 0) begin
                if (win == COMMA_V) begin m_anchor = m_n; m_cnt = 1; end
            end else if (((m_n - m_anchor) % 8) == 0) begin
                if (win == COMMA_V) m_cnt = m_cnt + 1;
                else begin m_anchor = -1; m_cnt = 0; end
            end
            if (m_anchor >= 0 && m_cnt == N_C) begin
                m_locked = 1'b1; m_lock_pos = m_n;
            end
        end
        exp_active = m_locked;
    endfunction

    task automatic drive_edge(input logic b, input logic r);
        rx.data_in = b;
        reset      = r;
        @(posedge clk);
        #1;
        model_step(b, r);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 10; k++) begin
            drive_edge(1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if ({rx.data_out, rx.valid_out, rx.byte_strobe, rx.active} !== 11'h000) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h/%b/%b/%b want 00/0/0/0", k,
                         rx.data_out, rx.valid_out, rx.byte_strobe, rx.active);
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] v;
        logic       bits [3];
        int         k;
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
        k = 0;
        for (int j = 0; j < 3; j++) begin
            drive_edge(bits[j], 1'b1);
            k++;
        end
        for (int c = 0; c < 4; c++) begin
            v = COMMA_V;
            for (int i = 7; i >= 0; i--) begin
                drive_edge(v[i], 1'b1);
                k++;
                n_checks++;
                if (rx.active !== (k >= 35) || rx.byte_strobe !== 1'b0 || exp_active !== (k >= 35)) begin
                    n_fail++;
                    $display("FAIL lock bit %0d: active=%b strobe=%b want active=%b strobe=0",
                             k, rx.active, rx.byte_strobe, (k >= 35));
                end
            end
        end
    endtask

    task automatic test_data();
        logic [7:0] bytes_v [4];
        logic [7:0] v;
        int t, last_t;
        bytes_v[0] = 8'hFF; bytes_v[1] = 8'hEE; bytes_v[2] = 8'hDD; bytes_v[3] = 8'hCC;
        t = 0; last_t = 0;
        for (int b = 0; b < 4; b++) begin
            v = bytes_v[b];
            for (int i = 7; i >= 0; i--) begin
                drive_edge(v[i], 1'b1);
                t++;
                n_checks++;
                if (rx.byte_strobe !== (i == 0)) begin
                    n_fail++;
                    $display("FAIL data strobe byte %0d bit %0d: got %b want %b", b, i, rx.byte_strobe, (i == 0));
                end
                if (i == 0) begin
                    n_checks++;
                    if (rx.data_out !== v || rx.valid_out !== 1'b1 || (b > 0 && t - last_t != 8)) begin
                        n_fail++;
                        $display("FAIL data byte %0d: got %h/%b period %0d want %h/1 period 8",
                                 b, rx.data_out, rx.valid_out, t - last_t, v);
                    end
                    last_t = t;
                end
            end
        end
    endtask

    task automatic test_idle_comma();
        logic [7:0] bytes_v [2];
        logic [7:0] v;
        bytes_v[0] = 8'hBC; bytes_v[1] = 8'h55;
        for (int b = 0; b < 2; b++) begin
            v = bytes_v[b];
            for (int i = 7; i >= 0; i--) drive_edge(v[i], 1'b1);
            n_checks++;
            if (rx.data_out !== v || rx.valid_out !== (b == 1) || rx.byte_strobe !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_comma byte %0d: got %h/%b/%b want %h/%b/1",
                         b, rx.data_out, rx.valid_out, rx.byte_strobe, v, (b == 1));
            end
        end
    endtask

    // Sends n_commas commas then an optional 0x55, checking the model every bit.
    task automatic test_comma_run(input string tag, input int n_commas, input bit tail, input logic want_active);
        logic [7:0] v;
        for (int c = 0; c < n_commas + int'(tail); c++) begin
            v = (c < n_commas) ? COMMA_V : 8'h55;
            for (int i = 7; i >= 0; i--) begin
                drive_edge(v[i], 1'b1);
                n_checks++;
                if ({rx.data_out, rx.valid_out, rx.byte_strobe, rx.active} !==
                    {exp_data, exp_valid, exp_strobe, exp_active}) begin
                    n_fail++;
                    $display("FAIL %s model byte %0d bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", tag, c, i,
                             rx.data_out, rx.valid_out, rx.byte_strobe, rx.active,
                             exp_data, exp_valid, exp_strobe, exp_active);
                end
            end
        end
        n_checks++;
        if (rx.active !== want_active) begin
            n_fail++;
            $display("FAIL %s end active: got %b want %b", tag, rx.active, want_active);
        end
    endtask

    task automatic test_failed_lock();
        drive_edge(1'b0, 1'b0);
        drive_edge(1'b0, 1'b0);
        test_comma_run("failed_lock", 3, 1'b1, 1'b0);
        test_comma_run("relock", 4, 1'b0, 1'b1);
    endtask

    task automatic test_mid_byte_reset();
        for (int k = 0; k < 3; k++) drive_edge(1'($urandom_range(0, 1)), 1'b1);
        drive_edge(1'b1, 1'b0);
        n_checks++;
        if ({rx.data_out, rx.valid_out, rx.byte_strobe, rx.active} !== 11'h000) begin
            n_fail++;
            $display("FAIL mid_byte_reset: got %h/%b/%b/%b want 00/0/0/0",
                     rx.data_out, rx.valid_out, rx.byte_strobe, rx.active);
        end
        test_comma_run("post_reset_partial", 3, 1'b1, 1'b0);
        test_comma_run("post_reset_lock", 4, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] v;
        int junk;
        for (int run = 0; run < 4; run++) begin
            drive_edge(1'b0, 1'b0);
            junk = $urandom_range(0, 7);
            for (int k = 0; k < junk; k++) drive_edge(1'($urandom_range(0, 1)), 1'b1);
            for (int b = 0; b < 40; b++) begin
                if (b < 4) v = COMMA_V;
                else if ($urandom_range(0, 3) == 0) v = COMMA_V;
                else v = 8'($urandom);
                for (int i = 7; i >= 0; i--) begin
                    drive_edge(v[i], 1'b1);
                    n_checks++;
                    if ({rx.data_out, rx.valid_out, rx.byte_strobe, rx.active} !==
                        {exp_data, exp_valid, exp_strobe, exp_active}) begin
                        n_fail++;
                        $display("FAIL random run %0d byte %0d bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b",
                                 run, b, i, rx.data_out, rx.valid_out, rx.byte_strobe, rx.active,
                                 exp_data, exp_valid, exp_strobe, exp_active);
                    end
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        rx.data_in = 1'b0;
        model_step(1'b0, 1'b0);
        test_reset();
        test_lock();
        test_data();
        test_idle_comma();
        test_failed_lock();
        test_mid_byte_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side neighbour of the PHY transmit path; consumes the 1-bit serial stream the parallel-to-serial stage produces on the fast clock.
- Locks byte alignment by searching for the COMMA (K28.5, 8'hBC) idle byte and requiring N_COMMA consecutive aligned commas before going ACTIVE.
- In ACTIVE it emits each 8-bit byte with a valid flag; COMMA bytes are reported as idle (valid_out=0).
- Feeds the lane demux / byte-striping receive stage.

Parameters:
- DATA_W, 8, byte width; fixed at 8 for this PHY.
- COMMA, 8'hBC, alignment/idle symbol.
- N_COMMA, 4, consecutive aligned commas required to enter ACTIVE (range 1..15).

Ports:
- clk  in  1  serial bit clock (the 32f domain); every rising edge carries one bit.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- data_in  in  1  serial data, MSB of each byte first.
- data_out  out  8  last assembled byte.
- valid_out  out  1  1 = data_out is a data byte; 0 = idle/COMMA or not aligned.
- byte_strobe  out  1  one-cycle pulse when data_out is updated (ACTIVE only).
- active  out  1  1 while state == ACTIVE.

Behaviour:
- Reset (reset==0 at a clk edge): shift register sr=0, state=SEARCH, bit_cnt=0, comma_cnt=0; data_out=0, valid_out=0, byte_strobe=0, active=0. Reset has priority over every other event, including mid-byte in ACTIVE.
- Shift register: every clk edge, sr <= {sr[6:0], data_in}. Window w = {sr[6:0], data_in} is combinational and holds the 8 bits ending with the current bit.
- SEARCH state:
  - Examines w on every edge; any bit offset may match.
  - On w==COMMA: bit_cnt<=0 and comma_cnt<=1. If N_COMMA==1, go to ACTIVE; otherwise go to ALIGN.
- ALIGN state:
  - bit_cnt increments modulo 8.
  - At bit_cnt==7, w is checked. If w==COMMA, comma_cnt++; when the new count equals N_COMMA, go to ACTIVE.
  - If w!=COMMA at bit_cnt==7: return to SEARCH and set comma_cnt=0. No re-check of the same window is made.
- ACTIVE state:
  - bit_cnt continues modulo 8.
  - At bit_cnt==7 (registered on that edge): data_out<=w, valid_out<=(w!=COMMA), byte_strobe<=1.
  - On all other edges, byte_strobe<=0 and data_out/valid_out hold.
  - ACTIVE is sticky; only reset leaves it.
- Outputs outside ACTIVE: data_out=0, valid_out=0, byte_strobe=0.
- active is registered and rises on the edge that completes the N_COMMA-th comma.
- Latency: the byte's last bit is sampled at edge t; data_out/valid_out/byte_strobe are visible after edge t. The first data byte after lock appears 8 edges after active rises.
- byte_strobe period in ACTIVE is exactly 8 clk cycles, never back-to-back.
- Counter widths: bit_cnt 3 bits (wrap-around intended); comma_cnt 4 bits, saturating at N_COMMA.

Decomposition:
- Shared package phy_pkg holds:
  - localparam COMMA_K28_5 = 8'hBC
  - LANE_W = 8
  - state encoding rx_state_t {SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2}
- The shift register and output registers stay in the top module.
- One natural sub-module, comma_align_fsm: inputs w_is_comma and bit_cnt; outputs state, comma_cnt, and a byte_boundary pulse.

Test Plan:
- Hold reset=0 for 10 clk cycles with random data_in -> data_out=8'h00, valid_out=0, byte_strobe=0, active=0 throughout.
- Release reset, send 3 junk bits (1,0,1), then 4×8'hBC MSB-first -> active rises on the edge of the 35th bit; byte_strobe stays 0 before that.
- After lock, send 8'hFF, 8'hEE, 8'hDD, 8'hCC -> byte_strobe pulses every 8 cycles; data_out=FF/EE/DD/CC with valid_out=1 on each strobe.
- In ACTIVE, send 8'hBC then 8'h55 -> data_out=BC with valid_out=0, then data_out=55 with valid_out=1.
- Fresh lock attempt: send 3×8'hBC then 8'h55 -> returns to SEARCH, active=0. Then send 4×8'hBC -> active=1.
- Drive reset=0 for one edge mid-byte in ACTIVE -> all outputs 0 on the next cycle; lock requires 4 new commas (3 commas plus data leaves active=0).
